// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - geometry, control codes and FSM states for the text cell store
package text_pkg;

  localparam int ROWS   = 15;
  localparam int COLS   = 40;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 6;
  localparam int CHAR_W = 8;
  localparam int ADDR_W = 10;
  localparam int CELLS  = ROWS * COLS;

  localparam logic [CHAR_W-1:0] BLANK_CHAR = 8'h20;

  localparam logic [CHAR_W-1:0] CC_CR = 8'h0D;
  localparam logic [CHAR_W-1:0] CC_BS = 8'h08;
  localparam logic [CHAR_W-1:0] CC_FF = 8'h0C;

  typedef enum logic [2:0] {
    INIT_CLEAR,
    IDLE,
    CLEAR,
    SCROLL,
    SCROLL_CLR
  } state_t;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/text_buffer_ctrl_if.sv
// rtl/text_buffer_ctrl_if.sv - character byte stream handshake into the text buffer
interface text_buffer_ctrl_if;
  import text_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_char;

  modport master (output in_valid, output in_char, input in_ready);
  modport slave  (input in_valid, input in_char, output in_ready);

endinterface

// File: rtl/text_char_ram.sv
// rtl/text_char_ram.sv - 600-cell character store, one sync write, two async reads
module text_char_ram
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [CHAR_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  output logic [CHAR_W-1:0] rdata_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [CHAR_W-1:0] rdata_b
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(CELLS - 1);

  logic [CHAR_W-1:0] mem [CELLS];

  always_ff @(posedge clk) begin
    if (we && waddr <= LAST) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a <= LAST) ? mem[raddr_a] : BLANK_CHAR;
  assign rdata_b = (raddr_b <= LAST) ? mem[raddr_b] : BLANK_CHAR;

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - cursor-driven writer for the VGA text cell store
module text_buffer_ctrl
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  text_buffer_ctrl_if.slave stream,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [CHAR_W-1:0] rd_char,
  output logic [ROW_W-1:0]  cur_row,
  output logic [COL_W-1:0]  cur_col,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CNT_LAST   = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0] SCROLL_END = ADDR_W'(CELLS - COLS - 1);
  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(ROWS - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;

  logic              accept;
  logic              is_ctrl;
  logic              at_origin;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] bs_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [CHAR_W-1:0] rd_data;
  logic [CHAR_W-1:0] src_data;
  logic              rd_in_range;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [CHAR_W-1:0] wdata;

  assign stream.in_ready = (state == IDLE);
  assign busy            = (state != IDLE);
  assign accept          = stream.in_valid && stream.in_ready;
  assign is_ctrl         = (stream.in_char < BLANK_CHAR);
  assign at_origin       = (cur_row == '0) && (cur_col == '0);
  assign cur_addr        = cell_addr(cur_row, cur_col);
  assign bs_addr         = (cur_col != '0) ? cell_addr(cur_row, cur_col - COL_W'(1))
                                           : cell_addr(cur_row - ROW_W'(1), COL_LAST);
  assign rd_addr         = cell_addr(rd_row, rd_col);
  assign rd_in_range     = (rd_row < ROW_W'(ROWS)) && (rd_col < COL_W'(COLS));

  // The renderer never sees stale power-up contents while the initial sweep runs.
  assign rd_char = (state == INIT_CLEAR || !rd_in_range) ? BLANK_CHAR : rd_data;

  always_comb begin
    we    = 1'b0;
    waddr = cnt;
    wdata = BLANK_CHAR;
    case (state)
      INIT_CLEAR, CLEAR, SCROLL_CLR: we = 1'b1;
      SCROLL: begin
        we    = 1'b1;
        wdata = src_data;
      end
      IDLE: begin
        if (accept) begin
          if (stream.in_char == CC_BS) begin
            we    = !at_origin;
            waddr = bs_addr;
          end else if (!is_ctrl) begin
            we    = 1'b1;
            waddr = cur_addr;
            wdata = stream.in_char;
          end
        end
      end
      default: we = 1'b0;
    endcase
  end

  text_char_ram u_ram (
    .clk     (clk),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .raddr_a (rd_addr),
    .rdata_a (rd_data),
    .raddr_b (cnt + ADDR_W'(COLS)),
    .rdata_b (src_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= INIT_CLEAR;
      cnt     <= '0;
      cur_row <= '0;
      cur_col <= '0;
    end else begin
      case (state)
        INIT_CLEAR, CLEAR: begin
          if (cnt == CNT_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            cur_row <= '0;
            cur_col <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        SCROLL: begin
          if (cnt == SCROLL_END) state <= SCROLL_CLR;
          cnt <= cnt + ADDR_W'(1);
        end
        SCROLL_CLR: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            if (stream.in_char == CC_CR) begin
              cur_col <= '0;
              if (cur_row != ROW_LAST) begin
                cur_row <= cur_row + ROW_W'(1);
              end else begin
                state <= SCROLL;
                cnt   <= '0;
              end
            end else if (stream.in_char == CC_BS) begin
              if (cur_col != '0) begin
                cur_col <= cur_col - COL_W'(1);
              end else if (cur_row != '0) begin
                cur_row <= cur_row - ROW_W'(1);
                cur_col <= COL_LAST;
              end
            end else if (stream.in_char == CC_FF) begin
              state <= CLEAR;
              cnt   <= '0;
            end else if (!is_ctrl) begin
              if (cur_col != COL_LAST) begin
                cur_col <= cur_col + COL_W'(1);
              end else begin
                cur_col <= '0;
                if (cur_row != ROW_LAST) begin
                  cur_row <= cur_row + ROW_W'(1);
                end else begin
                  state <= SCROLL;
                  cnt   <= '0;
                end
              end
            end
          end
        end
        default: state <= INIT_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// tb/tb_text_buffer_ctrl.sv - directed scoreboard bench for text_buffer_ctrl
module tb_text_buffer_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] rd_row;
  logic [5:0] rd_col;
  logic [7:0] rd_char;
  logic [3:0] cur_row;
  logic [5:0] cur_col;
  logic       busy;

  always #5 clk = ~clk;

  text_buffer_ctrl_if bus ();

  text_buffer_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .stream  (bus),
    .rd_row  (rd_row),
    .rd_col  (rd_col),
    .rd_char (rd_char),
    .cur_row (cur_row),
    .cur_col (cur_col),
    .busy    (busy)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]  mem_m [600];
  int          m_row;
  int          m_col;
  bit          m_home_pending;
  logic [15:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_blank();
    for (int i = 0; i < 600; i++) mem_m[i] = 8'h20;
  endtask

  task automatic model_next_row();
    m_col = 0;
    if (m_row < 14) begin
      m_row++;
    end else begin
      for (int i = 0; i < 560; i++) mem_m[i] = mem_m[i+40];
      for (int i = 560; i < 600; i++) mem_m[i] = 8'h20;
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (m_home_pending) begin
      m_row = 0;
      m_col = 0;
      m_home_pending = 0;
    end
    if (b == 8'h0D) begin
      model_next_row();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        mem_m[m_row*40+m_col] = 8'h20;
      end else if (m_row > 0) begin
        m_row--;
        m_col = 39;
        mem_m[m_row*40+m_col] = 8'h20;
      end
    end else if (b == 8'h0C) begin
      model_blank();
      m_home_pending = 1;
    end else if (b >= 8'h20) begin
      mem_m[m_row*40+m_col] = b;
      if (m_col < 39) m_col++;
      else model_next_row();
    end
  endtask

  task automatic pop_cursor(input string tag);
    logic [15:0] e;
    e = exp_q.pop_front();
    check(tag, {4'h0, cur_row, 2'b00, cur_col}, e);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = b;
    while (bus.in_ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) check({tag, "_ready_timeout"}, bus.in_ready, 1);
    model_byte(b);
    exp_q.push_back({m_row[7:0], m_col[7:0]});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    pop_cursor({tag, "_cursor"});
  endtask

  task automatic wait_sweep(input string tag);
    int n = 0;
    int bad = 0;
    while (busy === 1'b1 && n < 3000) begin
      if (bus.in_ready !== 1'b0) bad++;
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, "_busy_cycles"}, n, 600);
    check({tag, "_ready_low"}, bad, 0);
    if (m_home_pending) begin
      m_row = 0;
      m_col = 0;
      m_home_pending = 0;
    end
  endtask

  task automatic check_cursor(input string tag);
    check(tag, {4'h0, cur_row, 2'b00, cur_col}, {m_row[7:0], m_col[7:0]});
  endtask

  task automatic check_screen(input string tag);
    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 40; c++) begin
        rd_row = 4'(r);
        rd_col = 6'(c);
        #1;
        check($sformatf("%s_cell_%0d_%0d", tag, r, c), rd_char, mem_m[r*40+c]);
      end
    end
  endtask

  task automatic read_cell(input int r, input int c, input logic [7:0] exp, input string tag);
    rd_row = 4'(r);
    rd_col = 6'(c);
    #1;
    check(tag, rd_char, exp);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_char  = 8'h00;
    rd_row = '0;
    rd_col = '0;
    reset  = 1'b1;
    m_row  = 0;
    m_col  = 0;
    m_home_pending = 0;
    model_blank();

    @(posedge clk);
    #1;
    check("reset_busy", busy, 1);
    check("reset_ready", bus.in_ready, 0);
    check_cursor("reset_cursor");

    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_sweep("init");
    check_cursor("init_cursor");
    check_screen("init");
    read_cell(15, 0, 8'h20, "oob_row");
    read_cell(0, 45, 8'h20, "oob_col");

    send_byte(8'h41, "first");
    read_cell(0, 0, 8'h41, "first_cell");
    for (int i = 1; i < 40; i++) send_byte(8'h41 + 8'(i), "row0");
    check_screen("row0");

    send_byte(8'h0C, "ff_data");
    wait_sweep("ff_data");
    check_cursor("ff_cursor");
    check_screen("ff_data");

    bus.in_valid = 1'b1;
    for (int i = 0; i < 600; i++) begin
      bus.in_char = 8'h42;
      check("stream_ready", bus.in_ready, 1);
      model_byte(8'h42);
      exp_q.push_back({m_row[7:0], m_col[7:0]});
      @(posedge clk);
      #1;
      pop_cursor("stream_cursor");
    end
    bus.in_valid = 1'b0;
    wait_sweep("scroll");
    check_cursor("scroll_cursor");
    check_screen("scroll");

    send_byte(8'h0C, "ff2");
    wait_sweep("ff2");
    for (int i = 0; i < 3; i++) send_byte(8'h0D, "cr_down");
    for (int i = 0; i < 40; i++) send_byte(8'h61 + 8'(i % 26), "row3");
    send_byte(8'h08, "bs_wrap");
    read_cell(3, 39, 8'h20, "bs_wrap_cell");
    for (int i = 0; i < 22; i++) send_byte(8'h08, "bs_step");
    send_byte(8'h0D, "cr_mid");
    send_byte(8'h05, "ignored_ctrl");
    check_screen("moves");

    send_byte(8'h0C, "ff3");
    wait_sweep("ff3");
    send_byte(8'h08, "bs_origin");
    check_screen("bs_origin");

    send_byte(8'h0C, "ff_hold");
    send_byte(8'h5A, "held_byte");
    check_screen("held_byte");

    send_byte(8'h0C, "ff4");
    wait_sweep("ff4");
    for (int i = 0; i < 11; i++) send_byte(8'h0D, "cr_to11");
    send_byte(8'h51, "q_row11");
    for (int i = 0; i < 3; i++) send_byte(8'h0D, "cr_to14");
    send_byte(8'h0D, "cr_scroll");
    repeat (300) @(posedge clk);
    #1;
    reset = 1'b1;
    #2;
    model_blank();
    m_row = 0;
    m_col = 0;
    check("midreset_ready", bus.in_ready, 0);
    check("midreset_busy", busy, 1);
    check_cursor("midreset_cursor");
    read_cell(11, 0, 8'h20, "midreset_init_read");
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_sweep("reinit");
    check_cursor("reinit_cursor");
    check_screen("reinit");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
- Owns the 15x40 character-cell store that the VGA text renderer reads each pixel.
- Accepts a byte stream of character IDs over a valid/ready handshake and writes them at a hardware cursor.
- Handles wrap, newline, backspace, full-screen clear and one-line scroll-up.
- Provides a combinational read port indexed by the renderer's char_row/char_col, returning character_id.

Parameters:
ROWS, 15, text lines on screen
COLS, 40, characters per line
ROW_W, 4, row index width
COL_W, 6, column index width
CHAR_W, 8, character ID width
ADDR_W, 10, linear cell address width (ROWS*COLS = 600 cells)
BLANK_CHAR, 8'h20, ID written to cleared cells

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  in_char is valid this cycle
in_ready  out  1  controller accepts in_char this cycle
in_char  in  CHAR_W  character ID or control code
rd_row  in  ROW_W  renderer cell row (char_row)
rd_col  in  COL_W  renderer cell column (char_col)
rd_char  out  CHAR_W  character ID at (rd_row, rd_col), combinational
cur_row  out  ROW_W  cursor row
cur_col  out  COL_W  cursor column
busy  out  1  clear or scroll sweep in progress

Behaviour:
- Reset is asynchronous and active-high. It forces state INIT_CLEAR, sweep counter 0, cur_row 0, cur_col 0, in_ready 0 and busy 1. Cell contents are not reset; they are swept.
- Cell address = row*COLS + col, computed in ADDR_W bits.
- Accept rule: a byte is accepted only when in_valid && in_ready. in_ready = (state == IDLE). Each accepted byte takes effect on that clock edge.
- States:
  - INIT_CLEAR/CLEAR: write BLANK_CHAR to address cnt. cnt increments 0..599. At 599, cursor goes to (0,0) and the state goes to IDLE. Duration is 600 cycles.
  - IDLE: decode the accepted byte.
  - SCROLL: cell[cnt] <= cell[cnt+COLS] for cnt 0..559 (560 cycles), then go to SCROLL_CLR.
  - SCROLL_CLR: cells 560..599 <= BLANK_CHAR (40 cycles), then go to IDLE. Total scroll time is 600 cycles.
- Decode in IDLE:
  - 8'h0D (CR/newline): cur_col <= 0. If cur_row < ROWS-1, cur_row++; otherwise enter SCROLL and cur_row stays ROWS-1.
  - 8'h08 (BS):
    - if cur_col > 0: cur_col-- and write BLANK_CHAR at the new position.
    - else if cur_row > 0: cur_row--, cur_col <= COLS-1, and write BLANK_CHAR there.
    - at (0,0): no-op.
  - 8'h0C (FF): enter CLEAR, cnt <= 0.
  - Other codes < 8'h20: ignored, but still consumed.
  - Any other value: write it at the cursor.
    - If cur_col < COLS-1, cur_col++.
    - Otherwise cur_col <= 0 and advance the row as for CR, including SCROLL at the last row.
- busy = 1 in INIT_CLEAR, CLEAR, SCROLL and SCROLL_CLR.
- Read port:
  - rd_char = cell[rd_row*COLS + rd_col], purely combinational.
  - Returns BLANK_CHAR if rd_row >= ROWS or rd_col >= COLS.
  - Returns BLANK_CHAR throughout INIT_CLEAR.
  - During CLEAR/SCROLL the renderer sees live, partially updated contents; no tearing protection.
- Cursor outputs are registered and change only on the accepted-byte edge or at the end of a sweep.
- Reset mid-sweep: the sweep is abandoned and INIT_CLEAR restarts from cnt 0.
- A byte presented while busy is held by the source; it is not dropped and not accepted.

Decomposition:
- Package text_pkg holds:
  - ROWS, COLS and width constants; BLANK_CHAR;
  - control codes CC_CR, CC_BS, CC_FF;
  - state enum {INIT_CLEAR, IDLE, CLEAR, SCROLL, SCROLL_CLR}.
- Sub-module text_char_ram: 600 x CHAR_W register array with one synchronous write port and two asynchronous read ports (renderer, scroll source).
- The controller FSM, cursor and counter stay in text_buffer_ctrl.

Test Plan:
- Reset release:
  - busy = 1 and in_ready = 0 for exactly 600 cycles.
  - Afterwards every (r,c) reads 8'h20 and the cursor is (0,0).
  - rd_row = 15 or rd_col = 45 reads 8'h20.
- Write 8'h41 at (0,0):
  - rd_char(0,0) = 8'h41 the next cycle; cursor (0,1).
  - Then 39 more bytes: cursor (1,0), row 0 fully written.
- Back-to-back with in_valid held high:
  - one byte is accepted per cycle in IDLE.
  - After 600 bytes of 8'h42 from (0,0), SCROLL starts and busy = 1 for 600 cycles.
  - Afterwards rows 0-13 hold 8'h42, row 14 holds 8'h20 and the cursor is (14,0).
- Cursor moves:
  - CR at (3,17) gives cursor (4,0).
  - BS at (4,0) gives (3,39) with cell (3,39) = 8'h20.
  - BS at (0,0) changes nothing.
  - 8'h05 is consumed and ignored.
- FF with data present: busy for 600 cycles, all cells 8'h20, cursor (0,0).
- Reset mid-scroll:
  - Assert reset at scroll cycle 300: in_ready drops and the cursor is (0,0) immediately.
  - A full 600-cycle INIT_CLEAR follows, then all cells read 8'h20.
